apb_req_arbiter: RTL and testbench
==================================

APB_REQ_ARBITER -- requirements
Module: apb_req_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT, 16, maximum ACCESS cycles without pready before abort (legal 1..255).
REQ-002 SHALL have port: clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: req_i  in  4  per-requester transfer request, held until done.
REQ-005 SHALL have port: wr_i  in  4  per-requester direction: 1 write, 0 read.
REQ-006 SHALL have port: addr_i  in  48  packed addresses; requester k at [12k+11:12k].
REQ-007 SHALL have port: wdata_i  in  128  packed write data; requester k at [32k+31:32k].
REQ-008 SHALL have port: gnt_o  out  4  one-hot grant; high from SETUP through ACCESS.
REQ-009 SHALL have port: done_o  out  4  one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port: err_o  out  1  timeout flag; valid only while any done_o bit is high.
REQ-011 SHALL have port: rdata_o  out  32  read data from the last completed read.
REQ-012 SHALL have ports: psel, penable, pwrite  out  1 each  bus control.
REQ-013 SHALL have ports: paddr  out  12; pwdata  out  32; sel_port  out  3, equal to paddr[10:8].
REQ-014 SHALL have ports: pready  in  1; prdata  in  32.

Function
REQ-015 SHALL implement states IDLE, SETUP and ACCESS; all outputs SHALL be registered.
REQ-016 IDLE: if any eligible req_i bit is high, SHALL select a winner round-robin, starting the search at last_grant+1 mod 4.
REQ-017 A requester whose done_o bit is high in the current cycle SHALL be ineligible in that cycle.
REQ-018 On selection, SHALL latch the winner's addr, wr and wdata, and SHALL update last_grant to the winner.
REQ-019 On selection, the next cycle SHALL be SETUP with psel=1, penable=0, gnt_o one-hot, paddr/pwrite driven from the latched values, and pwdata = latched wdata for a write or 0 for a read.
REQ-020 SETUP SHALL last exactly one cycle, then enter ACCESS with penable=1; all other bus outputs SHALL be held.
REQ-021 ACCESS with pready=1: next cycle SHALL be IDLE, with psel=penable=0, gnt_o=0, the winner's done_o bit=1 and err_o=0.
REQ-022 ACCESS with pready=1 on a read: rdata_o SHALL capture prdata; a write SHALL leave rdata_o unchanged.
REQ-023 An 8-bit counter SHALL clear on SETUP entry and SHALL increment each ACCESS cycle with pready=0.
REQ-024 When the counter reaches TIMEOUT-1 while pready=0, next cycle SHALL be IDLE with the done_o pulse and err_o=1; rdata_o SHALL be unchanged.
REQ-025 A req_i deassertion mid-transfer SHALL NOT abort the transfer; done_o SHALL still pulse.
REQ-026 Minimum transfer SHALL be 3 cycles (IDLE-select, SETUP, ACCESS), and each completion SHALL be followed by at least one IDLE cycle.
REQ-027 The wr_i, addr_i and wdata_i values of a non-granted requester SHALL have no effect.
REQ-028 While in IDLE with no eligible request: psel=penable=pwrite=0, paddr=0, pwdata=0, sel_port=0.

Reset
REQ-029 rst=0, asynchronously and at any state including mid-ACCESS: state=IDLE; gnt_o=0; done_o=0; err_o=0; rdata_o=0; psel=penable=pwrite=0; paddr=0; pwdata=0; sel_port=0; counter=0; last_grant=3, so requester 0 has first priority.
REQ-030 A transfer interrupted by reset SHALL produce no done_o pulse.

Verification
REQ-031 Scenario: req_i=0001, wr=1, addr0=0x204, wdata0=0xA5A5A5A5, pready=1 in the first ACCESS cycle -> psel 2 cycles, penable 1 cycle, paddr=0x204, sel_port=2, done_o=0001, err_o=0.
REQ-032 Scenario: req_i=1111 held, all pready=1 -> grant order 0,1,2,3,0; no requester granted twice consecutively.
REQ-033 Scenario: read from requester 2, addr=0x5F0, pready low for 3 ACCESS cycles, then pready=1 with prdata=0xDEADBEEF -> rdata_o=0xDEADBEEF, done_o=0100.
REQ-034 Scenario: TIMEOUT=16, pready held 0 -> exactly 16 ACCESS cycles, then done_o pulse with err_o=1 and rdata_o unchanged.
REQ-035 Scenario: req_i=0010 held through done -> no re-grant in the done cycle; re-grant in the following cycle.
REQ-036 Scenario: rst asserted during ACCESS -> all outputs zero immediately, no done_o; after release, req_i=1000 and req_i=0001 together -> requester 0 granted first.

Source files
------------

// File: rtl/apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// apb_req_arbiter
//
// Purpose:
//   Arbitrates four requesters onto a single APB-style master port. A winner
//   is picked round-robin in IDLE, its address/direction/write data are
//   latched into the bus registers, and a SETUP -> ACCESS sequence is run.
//   ACCESS ends either on pready or after TIMEOUT cycles without pready
//   (abort, flagged on err_o). The requester gets a one-cycle done_o pulse in
//   both cases. All outputs are registered.
//
// Parameters:
//   TIMEOUT   maximum ACCESS cycles without pready before abort (1..255)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-low
//   req_i      [3:0]   per-requester transfer request, held until done
//   wr_i       [3:0]   per-requester direction, 1 = write, 0 = read
//   addr_i     [47:0]  packed addresses, requester k at [12k+11:12k]
//   wdata_i    [127:0] packed write data, requester k at [32k+31:32k]
//   gnt_o      [3:0]   one-hot grant, high from SETUP through ACCESS
//   done_o     [3:0]   one-cycle completion pulse to the granted requester
//   err_o              timeout flag, meaningful only while done_o != 0
//   rdata_o    [31:0]  read data of the last successfully completed read
//   psel, penable, pwrite, paddr[11:0], pwdata[31:0]  APB master outputs
//   sel_port   [2:0]   copy of paddr[10:8]
//   pready, prdata[31:0]  APB completer response
//   dbg_state  [1:0]   current FSM state (IDLE=0, SETUP=1, ACCESS=2)
//
// Requester handshake:
//   A requester raises req_i[k] (with wr_i/addr_i/wdata_i slice valid) and
//   keeps it high until it sees done_o[k]. done_o[k] is exactly one cycle;
//   err_o in that same cycle says whether the transfer timed out. The
//   request fields are sampled only in the cycle the requester wins, so they
//   may change afterwards, and dropping req_i[k] once granted does not cancel
//   the transfer. In the done_o cycle the finishing requester is not
//   eligible, so a still-high req_i[k] there is not mistaken for a new
//   request; it is considered again from the next cycle on.
// ---------------------------------------------------------------------------
module apb_req_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req_i,
    input  logic [3:0]   wr_i,
    input  logic [47:0]  addr_i,
    input  logic [127:0] wdata_i,
    output logic [3:0]   gnt_o,
    output logic [3:0]   done_o,
    output logic         err_o,
    output logic [31:0]  rdata_o,
    output logic         psel,
    output logic         penable,
    output logic         pwrite,
    output logic [11:0]  paddr,
    output logic [31:0]  pwdata,
    output logic [2:0]   sel_port,
    input  logic         pready,
    input  logic [31:0]  prdata,
    output logic [1:0]   dbg_state
);

    // -----------------------------------------------------------------------
    // FSM encoding
    // -----------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    // Counter value at which a stalled ACCESS is abandoned. The counter
    // starts at 0 in the first ACCESS cycle, so aborting when it holds
    // TIMEOUT-1 gives exactly TIMEOUT ACCESS cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]  state;
    logic [1:0]  last_grant;
    logic [7:0]  cnt;

    // -----------------------------------------------------------------------
    // Round-robin winner selection
    // -----------------------------------------------------------------------
    logic [3:0]  eligible;
    logic        any_eligible;
    logic [1:0]  winner;
    logic [3:0]  winner_oh;
    logic [11:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_wr;

    // The requester finishing this cycle still has req_i high (it drops it
    // after seeing done_o), so it is masked out here.
    assign eligible     = req_i & ~done_o;
    assign any_eligible = |eligible;

    // Search order: last_grant+1, +2, +3, +4 (mod 4). The first hit wins;
    // last_grant itself is checked last, so it only wins when alone.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found  = 1'b0;
        winner = 2'd0;
        idx    = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant + 2'(i);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        winner_oh         = 4'b0000;
        winner_oh[winner] = 1'b1;
    end

    assign win_addr  = addr_i[12*winner +: 12];
    assign win_wdata = wdata_i[32*winner +: 32];
    assign win_wr    = wr_i[winner];

    // -----------------------------------------------------------------------
    // Completion decode for the ACCESS state
    // -----------------------------------------------------------------------
    logic timed_out;
    logic finish;

    assign timed_out = !pready && (cnt == CNT_LAST);
    assign finish    = pready || timed_out;

    // -----------------------------------------------------------------------
    // Main sequential block. The bus output registers double as the latched
    // copy of the winner's request, so no separate request latch exists.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            last_grant <= 2'd3;
            cnt        <= 8'd0;
            gnt_o      <= 4'b0000;
            done_o     <= 4'b0000;
            err_o      <= 1'b0;
            rdata_o    <= 32'd0;
            psel       <= 1'b0;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= 12'd0;
            pwdata     <= 32'd0;
            sel_port   <= 3'd0;
        end else begin
            // Completion outputs are single-cycle pulses.
            done_o <= 4'b0000;
            err_o  <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (any_eligible) begin
                        state      <= ST_SETUP;
                        last_grant <= winner;
                        cnt        <= 8'd0;
                        gnt_o      <= winner_oh;
                        psel       <= 1'b1;
                        penable    <= 1'b0;
                        pwrite     <= win_wr;
                        paddr      <= win_addr;
                        sel_port   <= win_addr[10:8];
                        pwdata     <= win_wr ? win_wdata : 32'd0;
                    end
                end

                ST_SETUP: begin
                    state   <= ST_ACCESS;
                    penable <= 1'b1;
                end

                ST_ACCESS: begin
                    if (finish) begin
                        state   <= ST_IDLE;
                        done_o  <= gnt_o;
                        err_o   <= timed_out;
                        // Only a read that really completed updates rdata_o;
                        // an aborted read leaves the previous value.
                        if (pready && !pwrite) begin
                            rdata_o <= prdata;
                        end
                        gnt_o    <= 4'b0000;
                        psel     <= 1'b0;
                        penable  <= 1'b0;
                        pwrite   <= 1'b0;
                        paddr    <= 12'd0;
                        pwdata   <= 32'd0;
                        sel_port <= 3'd0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb_req_arbiter
//
// Directed bench for apb_req_arbiter (TIMEOUT = 16). Inputs change on the
// falling clock edge and outputs are sampled on the falling edge, half a
// cycle after the rising edge that updated them. Each check is an immediate
// assertion against a hand-computed value.
// ---------------------------------------------------------------------------
module tb_apb_req_arbiter;

    // -----------------------------------------------------------------------
    // Clock / reset
    // -----------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst = 1'b0;

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // DUT
    // -----------------------------------------------------------------------
    logic [3:0]   req_i   = '0;
    logic [3:0]   wr_i    = '0;
    logic [47:0]  addr_i  = '0;
    logic [127:0] wdata_i = '0;
    logic         pready  = 1'b0;
    logic [31:0]  prdata  = '0;
    logic [3:0]   gnt_o;
    logic [3:0]   done_o;
    logic         err_o;
    logic [31:0]  rdata_o;
    logic         psel;
    logic         penable;
    logic         pwrite;
    logic [11:0]  paddr;
    logic [31:0]  pwdata;
    logic [2:0]   sel_port;
    logic [1:0]   dbg_state;

    apb_req_arbiter #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .wr_i      (wr_i),
        .addr_i    (addr_i),
        .wdata_i   (wdata_i),
        .gnt_o     (gnt_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .rdata_o   (rdata_o),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .sel_port  (sel_port),
        .pready    (pready),
        .prdata    (prdata),
        .dbg_state (dbg_state)
    );

    // -----------------------------------------------------------------------
    // Check bookkeeping and driver helpers
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, "_psel"},     32'(psel),     32'd0);
        chk({tag, "_penable"},  32'(penable),  32'd0);
        chk({tag, "_pwrite"},   32'(pwrite),   32'd0);
        chk({tag, "_paddr"},    32'(paddr),    32'd0);
        chk({tag, "_pwdata"},   pwdata,        32'd0);
        chk({tag, "_sel_port"}, 32'(sel_port), 32'd0);
        chk({tag, "_gnt"},      32'(gnt_o),    32'd0);
    endtask

    // Round-robin expectations
    logic [3:0]  exp_g [5];
    logic [11:0] exp_a [5];

    // -----------------------------------------------------------------------
    // Directed sequence
    // -----------------------------------------------------------------------
    initial begin
        logic [3:0] prev_g;
        int         ng;
        int         acc_cycles;
        bit         seen_done;

        // ---------------- reset state ----------------
        #1;
        chk_bus_idle("rst0");
        chk("rst0_done",  32'(done_o),    32'd0);
        chk("rst0_err",   32'(err_o),     32'd0);
        chk("rst0_rdata", rdata_o,        32'd0);
        chk("rst0_state", 32'(dbg_state), 32'd0);
        step();
        step();
        rst = 1'b1;
        step();
        chk_bus_idle("idle_noreq");

        // ---------------- single write, requester 0 ----------------
        req_i   = 4'b0001;
        wr_i    = 4'b0001;
        addr_i  = {12'h0, 12'h0, 12'h0, 12'h204};
        wdata_i = {32'h0, 32'h0, 32'h0, 32'hA5A5A5A5};
        pready  = 1'b1;
        step();                                   // SETUP
        chk("wr_setup_psel",    32'(psel),      32'd1);
        chk("wr_setup_penable", 32'(penable),   32'd0);
        chk("wr_setup_gnt",     32'(gnt_o),     32'b0001);
        chk("wr_setup_paddr",   32'(paddr),     32'h204);
        chk("wr_setup_sel",     32'(sel_port),  32'd2);
        chk("wr_setup_pwrite",  32'(pwrite),    32'd1);
        chk("wr_setup_pwdata",  pwdata,         32'hA5A5A5A5);
        chk("wr_setup_state",   32'(dbg_state), 32'd1);
        step();                                   // ACCESS
        chk("wr_acc_psel",      32'(psel),      32'd1);
        chk("wr_acc_penable",   32'(penable),   32'd1);
        chk("wr_acc_paddr",     32'(paddr),     32'h204);
        chk("wr_acc_pwdata",    pwdata,         32'hA5A5A5A5);
        chk("wr_acc_state",     32'(dbg_state), 32'd2);
        step();                                   // done cycle
        chk("wr_done",          32'(done_o),    32'b0001);
        chk("wr_err",           32'(err_o),     32'd0);
        chk("wr_rdata",         rdata_o,        32'd0);
        chk_bus_idle("wr_done");
        req_i = 4'b0000;
        step();
        chk("wr_done_pulse",    32'(done_o),    32'd0);

        // ---------------- read, requester 2, 3 wait cycles ----------------
        req_i   = 4'b0100;
        wr_i    = 4'b0000;
        addr_i  = {12'h0, 12'h5F0, 12'h0, 12'h0};
        wdata_i = {32'h0, 32'h12345678, 32'h0, 32'h0};
        pready  = 1'b0;
        step();                                   // SETUP
        chk("rd_setup_gnt",    32'(gnt_o),    32'b0100);
        chk("rd_setup_paddr",  32'(paddr),    32'h5F0);
        chk("rd_setup_sel",    32'(sel_port), 32'd5);
        chk("rd_setup_pwrite", 32'(pwrite),   32'd0);
        chk("rd_setup_pwdata", pwdata,        32'd0);
        step();                                   // ACCESS 1
        step();                                   // ACCESS 2
        step();                                   // ACCESS 3
        chk("rd_wait_penable", 32'(penable),  32'd1);
        chk("rd_wait_done",    32'(done_o),   32'd0);
        step();                                   // ACCESS 4
        pready = 1'b1;
        prdata = 32'hDEADBEEF;
        step();                                   // done cycle
        chk("rd_done",  32'(done_o), 32'b0100);
        chk("rd_err",   32'(err_o),  32'd0);
        chk("rd_rdata", rdata_o,     32'hDEADBEEF);
        req_i  = 4'b0000;
        pready = 1'b0;
        prdata = 32'h0;
        step();

        // ---------------- timeout, read from requester 3 ----------------
        req_i  = 4'b1000;
        wr_i   = 4'b0000;
        addr_i = {12'h0AB, 12'h0, 12'h0, 12'h0};
        prdata = 32'hCAFEF00D;
        step();                                   // SETUP
        chk("to_setup_gnt", 32'(gnt_o), 32'b1000);
        acc_cycles = 0;
        seen_done  = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            step();
            if (done_o != 4'b0000) begin
                seen_done = 1'b1;
            end else if (psel && penable) begin
                acc_cycles++;
            end
        end
        chk("to_seen_done",  32'(seen_done),  32'd1);
        chk("to_acc_cycles", 32'(acc_cycles), 32'd16);
        chk("to_done",       32'(done_o),     32'b1000);
        chk("to_err",        32'(err_o),      32'd1);
        chk("to_rdata",      rdata_o,         32'hDEADBEEF);
        chk("to_psel",       32'(psel),       32'd0);
        req_i  = 4'b0000;
        prdata = 32'h0;
        step();
        chk("to_err_pulse",  32'(err_o),      32'd0);

        // ---------------- round robin, all four requesting ----------------
        exp_g[0] = 4'b0001; exp_a[0] = 12'h090;
        exp_g[1] = 4'b0010; exp_a[1] = 12'h1A1;
        exp_g[2] = 4'b0100; exp_a[2] = 12'h2B2;
        exp_g[3] = 4'b1000; exp_a[3] = 12'h3C3;
        exp_g[4] = 4'b0001; exp_a[4] = 12'h090;
        req_i   = 4'b1111;
        wr_i    = 4'b1111;
        addr_i  = {12'h3C3, 12'h2B2, 12'h1A1, 12'h090};
        wdata_i = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        pready  = 1'b1;
        prev_g  = 4'b0000;
        ng      = 0;
        for (int c = 0; c < 40 && ng < 5; c++) begin
            step();
            if (gnt_o != 4'b0000 && prev_g == 4'b0000) begin
                chk("rr_gnt",   32'(gnt_o), 32'(exp_g[ng]));
                chk("rr_paddr", 32'(paddr), 32'(exp_a[ng]));
                ng++;
            end
            prev_g = gnt_o;
        end
        chk("rr_grants", 32'(ng), 32'd5);
        // Requester 0 is in SETUP; withdraw every request mid-transfer.
        req_i = 4'b0000;
        step();                                   // ACCESS
        step();                                   // done cycle
        chk("rr_drop_done", 32'(done_o), 32'b0001);
        chk("rr_rdata",     rdata_o,     32'hDEADBEEF);
        step();
        chk_bus_idle("rr_after");

        // ---------------- held request: no re-grant in done cycle --------
        req_i = 4'b0010;
        wr_i  = 4'b0000;
        step();                                   // SETUP
        chk("hold_gnt1", 32'(gnt_o), 32'b0010);
        step();                                   // ACCESS
        step();                                   // done cycle
        chk("hold_done",  32'(done_o),    32'b0010);
        chk("hold_gnt0",  32'(gnt_o),     32'd0);
        step();                                   // IDLE, selects again
        chk("hold_idle_gnt",   32'(gnt_o),     32'd0);
        chk("hold_idle_state", 32'(dbg_state), 32'd0);
        step();                                   // SETUP again
        chk("hold_regnt", 32'(gnt_o), 32'b0010);
        step();                                   // ACCESS
        step();                                   // done cycle
        chk("hold_done2", 32'(done_o), 32'b0010);
        req_i = 4'b0000;
        step();

        // ---------------- reset during ACCESS ----------------
        req_i  = 4'b0001;
        wr_i   = 4'b0001;
        addr_i = {12'h0, 12'h0, 12'h0, 12'h7FF};
        pready = 1'b0;
        step();                                   // SETUP
        step();                                   // ACCESS
        chk("mid_penable", 32'(penable), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk_bus_idle("mid_rst");
        chk("mid_rst_done",  32'(done_o),    32'd0);
        chk("mid_rst_rdata", rdata_o,        32'd0);
        chk("mid_rst_state", 32'(dbg_state), 32'd0);
        step();
        chk("mid_rst_done2", 32'(done_o),    32'd0);
        rst    = 1'b1;
        req_i  = 4'b1001;
        wr_i   = 4'b0000;
        addr_i = {12'h321, 12'h0, 12'h0, 12'h123};
        pready = 1'b1;
        step();                                   // SETUP
        chk("post_rst_gnt",   32'(gnt_o), 32'b0001);
        chk("post_rst_paddr", 32'(paddr), 32'h123);
        chk("post_rst_done",  32'(done_o), 32'd0);
        step();                                   // ACCESS
        step();                                   // done cycle
        chk("post_rst_done0", 32'(done_o), 32'b0001);
        req_i = 4'b1000;
        step();                                   // SETUP for requester 3
        chk("post_rst_gnt3",  32'(gnt_o), 32'b1000);
        step();                                   // ACCESS
        step();                                   // done cycle
        chk("post_rst_done3", 32'(done_o), 32'b1000);
        req_i = 4'b0000;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
